// File: rtl/aes_inv_mixcol_seq.sv
// Sequencer that time-shares an external combinational inverse-MixColumns unit
// across a 128-bit AES state, COLS_PER_CYCLE columns per pass, with valid/ready on both sides.
module aes_inv_mixcol_seq #(
  parameter int COLS_PER_CYCLE = 1,
  parameter int CNT_W          = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [127:0]                 in_block,
  input  logic                         in_bypass,
  output logic [32*COLS_PER_CYCLE-1:0] col_out,
  input  logic [32*COLS_PER_CYCLE-1:0] col_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [127:0]                 out_block,
  output logic                         busy,
  output logic [CNT_W-1:0]             blk_cnt
);

  localparam int SLICE_W = 32 * COLS_PER_CYCLE;
  localparam int NPASS   = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_IDX = 2'(NPASS - 1);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("aes_inv_mixcol_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [127:0]       buf_q, buf_d;
  logic [127:0]       res_q, res_d;
  logic [1:0]         idx_q, idx_d;
  logic               bypass_q, bypass_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      buf_q    <= '0;
      res_q    <= '0;
      idx_q    <= '0;
      bypass_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      res_q    <= res_d;
      idx_q    <= idx_d;
      bypass_q <= bypass_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    res_d     = res_q;
    idx_d     = idx_q;
    bypass_d  = bypass_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    col_out   = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_d    = in_block;
          bypass_d = in_bypass;
          // Final round skips the column unit entirely
          if (in_bypass) begin
            res_d   = in_block;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        col_out = buf_q[idx_q*SLICE_W +: SLICE_W];
        res_d[idx_q*SLICE_W +: SLICE_W] = col_in;
        if (idx_q == LAST_IDX) begin
          idx_d   = 2'd0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_block = res_q;
  assign busy      = (state_q != IDLE);
  assign blk_cnt   = cnt_q;

endmodule

// File: tb/tb_aes_inv_mixcol_seq.sv
// Directed self-checking bench for aes_inv_mixcol_seq: three instances (1, 2 and 4
// columns per pass), each wired to a behavioural inverse-MixColumns column unit.
module tb_aes_inv_mixcol_seq;

  localparam logic [127:0] BLK_A = {4{32'h8e4da1bc}};
  localparam logic [127:0] EXP_A = {4{32'hdb135345}};
  localparam logic [127:0] BLK_O = {32'hc6c6c6c6, 32'h00000000, 32'h01010101, 32'h8e4da1bc};
  localparam logic [127:0] EXP_O = {32'hc6c6c6c6, 32'h00000000, 32'h01010101, 32'hdb135345};
  localparam logic [127:0] BLK_U = {4{32'h01010101}};
  localparam logic [127:0] BLK_P = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] BLK_R = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstN;
  logic         inValid  [3];
  logic         inBypass [3];
  logic         outReady [3];
  logic [127:0] inBlock  [3];
  logic         inReady  [3];
  logic         outValid [3];
  logic         busy     [3];
  logic [127:0] outBlock [3];
  logic [15:0]  cnt1;
  logic [1:0]   cnt2, cnt4;
  logic [31:0]  colOut1, colIn1;
  logic [63:0]  colOut2, colIn2;
  logic [127:0] colOut4, colIn4;

  int assertCount = 0;
  int failCount   = 0;

  // GF(2^8) multiply with the AES reduction polynomial
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] invMixCol(input logic [31:0] c);
    logic [7:0] s0, s1, s2, s3;
    s0 = c[31:24]; s1 = c[23:16]; s2 = c[15:8]; s3 = c[7:0];
    return {gmul(s0,8'h0e) ^ gmul(s1,8'h0b) ^ gmul(s2,8'h0d) ^ gmul(s3,8'h09),
            gmul(s0,8'h09) ^ gmul(s1,8'h0e) ^ gmul(s2,8'h0b) ^ gmul(s3,8'h0d),
            gmul(s0,8'h0d) ^ gmul(s1,8'h09) ^ gmul(s2,8'h0e) ^ gmul(s3,8'h0b),
            gmul(s0,8'h0b) ^ gmul(s1,8'h0d) ^ gmul(s2,8'h09) ^ gmul(s3,8'h0e)};
  endfunction

  assign colIn1 = invMixCol(colOut1);
  assign colIn2 = {invMixCol(colOut2[63:32]), invMixCol(colOut2[31:0])};
  assign colIn4 = {invMixCol(colOut4[127:96]), invMixCol(colOut4[95:64]),
                   invMixCol(colOut4[63:32]), invMixCol(colOut4[31:0])};

  aes_inv_mixcol_seq #(.COLS_PER_CYCLE(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rstN),
    .in_valid(inValid[0]), .in_ready(inReady[0]), .in_block(inBlock[0]), .in_bypass(inBypass[0]),
    .col_out(colOut1), .col_in(colIn1),
    .out_valid(outValid[0]), .out_ready(outReady[0]), .out_block(outBlock[0]),
    .busy(busy[0]), .blk_cnt(cnt1));

  aes_inv_mixcol_seq #(.COLS_PER_CYCLE(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rstN),
    .in_valid(inValid[1]), .in_ready(inReady[1]), .in_block(inBlock[1]), .in_bypass(inBypass[1]),
    .col_out(colOut2), .col_in(colIn2),
    .out_valid(outValid[1]), .out_ready(outReady[1]), .out_block(outBlock[1]),
    .busy(busy[1]), .blk_cnt(cnt2));

  aes_inv_mixcol_seq #(.COLS_PER_CYCLE(4), .CNT_W(2)) dut4 (
    .clk(clk), .rst_n(rstN),
    .in_valid(inValid[2]), .in_ready(inReady[2]), .in_block(inBlock[2]), .in_bypass(inBypass[2]),
    .col_out(colOut4), .col_in(colIn4),
    .out_valid(outValid[2]), .out_ready(outReady[2]), .out_block(outBlock[2]),
    .busy(busy[2]), .blk_cnt(cnt4));

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge with the instance idle; handshake happens on the next edge
  task automatic applyStimulus(input int k, input logic [127:0] blk, input logic byp);
    checkOutput("ready before accept", 128'(inReady[k]), 128'd1);
    inValid[k]  = 1'b1;
    inBlock[k]  = blk;
    inBypass[k] = byp;
    @(posedge clk); #1;
    inValid[k]  = 1'b0;
    inBypass[k] = 1'b0;
  endtask

  // Cycles from handshake until out_valid, counting the cycle after the handshake as 1
  task automatic waitValid(input int k, output int lat);
    lat = 1;
    while (!outValid[k] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int seen;
    int lastCyc;
    logic [127:0] ordBlk;
    logic [127:0] seqIn  [3];
    logic [127:0] seqExp [3];
    logic [1:0]   smallCnt;

    ordBlk = BLK_O;
    seqIn[0] = BLK_A; seqExp[0] = EXP_A;
    seqIn[1] = BLK_U; seqExp[1] = BLK_U;
    seqIn[2] = BLK_O; seqExp[2] = EXP_O;
    for (int k = 0; k < 3; k++) begin
      inValid[k] = 1'b0; inBypass[k] = 1'b0; outReady[k] = 1'b1; inBlock[k] = '0;
    end

    rstN = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput("reset in_ready", 128'(inReady[0]), 128'd1);
    checkOutput("reset out_valid", 128'(outValid[0]), 128'd0);
    checkOutput("reset out_block", outBlock[0], 128'd0);
    checkOutput("reset col_out", 128'(colOut1), 128'd0);
    checkOutput("reset busy", 128'(busy[0]), 128'd0);
    checkOutput("reset blk_cnt", 128'(cnt1), 128'd0);
    #12 rstN = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single state, one column per pass");
    applyStimulus(0, BLK_A, 1'b0);
    waitValid(0, lat);
    checkOutput("t1 latency", 128'(lat), 128'd5);
    checkOutput("t1 out_block", outBlock[0], EXP_A);
    @(posedge clk); #1;
    checkOutput("t1 blk_cnt", 128'(cnt1), 128'd1);
    checkOutput("t1 in_ready after", 128'(inReady[0]), 128'd1);
    checkOutput("t1 out_valid after", 128'(outValid[0]), 128'd0);

    $display("[TB] column order");
    applyStimulus(0, BLK_O, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("order col_out", 128'(colOut1), 128'(ordBlk[i*32 +: 32]));
      @(posedge clk); #1;
    end
    checkOutput("order out_valid", 128'(outValid[0]), 128'd1);
    checkOutput("order out_block", outBlock[0], EXP_O);
    @(posedge clk); #1;
    checkOutput("order blk_cnt", 128'(cnt1), 128'd2);

    $display("[TB] bypass");
    applyStimulus(0, BLK_P, 1'b1);
    checkOutput("bypass out_valid", 128'(outValid[0]), 128'd1);
    checkOutput("bypass out_block", outBlock[0], BLK_P);
    checkOutput("bypass col_out", 128'(colOut1), 128'd0);
    @(posedge clk); #1;
    checkOutput("bypass blk_cnt", 128'(cnt1), 128'd3);

    $display("[TB] backpressure");
    outReady[0] = 1'b0;
    applyStimulus(0, BLK_U, 1'b0);
    waitValid(0, lat);
    checkOutput("bp latency", 128'(lat), 128'd5);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp out_valid held", 128'(outValid[0]), 128'd1);
      checkOutput("bp out_block held", outBlock[0], BLK_U);
      checkOutput("bp in_ready low", 128'(inReady[0]), 128'd0);
      @(posedge clk); #1;
    end
    checkOutput("bp blk_cnt before release", 128'(cnt1), 128'd3);
    outReady[0] = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp blk_cnt", 128'(cnt1), 128'd4);
    checkOutput("bp in_ready after", 128'(inReady[0]), 128'd1);
    checkOutput("bp out_valid after", 128'(outValid[0]), 128'd0);

    $display("[TB] in_valid held high, back-to-back");
    seen = 0;
    lastCyc = 0;
    inValid[0] = 1'b1;
    inBlock[0] = seqIn[0];
    @(posedge clk); #1;
    for (int c = 1; c <= 40 && seen < 3; c++) begin
      if (outValid[0]) begin
        checkOutput("b2b out_block", outBlock[0], seqExp[seen]);
        if (seen == 0) checkOutput("b2b first latency", 128'(c), 128'd5);
        else checkOutput("b2b interval", 128'(c - lastCyc), 128'd6);
        lastCyc = c;
        seen++;
        if (seen < 3) inBlock[0] = seqIn[seen];
        else inValid[0] = 1'b0;
      end else if (!inReady[0]) begin
        inBlock[0] = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk); #1;
    end
    inValid[0] = 1'b0;
    checkOutput("b2b blocks seen", 128'(seen), 128'd3);
    checkOutput("b2b blk_cnt", 128'(cnt1), 128'd7);

    $display("[TB] reset during RUN");
    applyStimulus(0, BLK_R, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst col_out idx2", 128'(colOut1), 128'h33333333);
    rstN = 1'b0;
    #1;
    checkOutput("rst out_valid", 128'(outValid[0]), 128'd0);
    checkOutput("rst in_ready", 128'(inReady[0]), 128'd1);
    checkOutput("rst blk_cnt", 128'(cnt1), 128'd0);
    checkOutput("rst busy", 128'(busy[0]), 128'd0);
    checkOutput("rst col_out", 128'(colOut1), 128'd0);
    checkOutput("rst out_block", outBlock[0], 128'd0);
    #2 rstN = 1'b1;
    @(posedge clk); #1;
    applyStimulus(0, BLK_O, 1'b0);
    waitValid(0, lat);
    checkOutput("post-rst latency", 128'(lat), 128'd5);
    checkOutput("post-rst out_block", outBlock[0], EXP_O);
    @(posedge clk); #1;
    checkOutput("post-rst blk_cnt", 128'(cnt1), 128'd1);

    $display("[TB] wider passes and counter wrap");
    for (int k = 1; k < 3; k++) begin
      for (int j = 0; j < 5; j++) begin
        applyStimulus(k, (j % 2) ? BLK_O : BLK_A, 1'b0);
        waitValid(k, lat);
        checkOutput("wide latency", 128'(lat), (k == 1) ? 128'd3 : 128'd2);
        checkOutput("wide out_block", outBlock[k], (j % 2) ? EXP_O : EXP_A);
        @(posedge clk); #1;
      end
      smallCnt = (k == 1) ? cnt2 : cnt4;
      checkOutput("wide blk_cnt wrap", 128'(smallCnt), 128'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
